// File: rtl/gmii_tx_frame_buf.sv
// gmii_tx_frame_buf
// Store-and-forward byte FIFO between the MAC TX framer and the GMII transmit pins.
// A frame is only released to GMII once its final byte is in the RAM. Frames that
// overflow the buffer are rewound and discarded. The inter-frame gap is enforced
// on the GMII side.
module gmii_tx_frame_buf #(
    parameter int ADDR_W     = 11,
    parameter int IFG_BYTES  = 12,
    parameter int AFULL_FREE = 1600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mac_data_valid,
    input  logic [7:0]  mac_tx_data,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        almost_full,
    output logic        frame_drop,
    output logic        tx_busy,
    output logic [15:0] tx_frame_cnt,
    output logic [15:0] drop_frame_cnt
);

    localparam int              DEPTH    = 2**ADDR_W;
    localparam int              PW       = ADDR_W + 1;
    localparam logic [PW-1:0]   DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0]   AF_THR   = PW'(AFULL_FREE);
    // R_IFG lasts IFG_BYTES-1 cycles; the R_IDLE read-issue cycle supplies the last idle byte.
    localparam int              IFG_LOAD = (IFG_BYTES > 1) ? (IFG_BYTES - 2) : 0;
    localparam int              IFG_W    = (IFG_LOAD > 0) ? $clog2(IFG_LOAD + 1) : 1;

    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_SEND, R_IFG}   rstate_t;

    wstate_t            r_wstate, w_wstate_nxt;
    rstate_t            r_rstate, w_rstate_nxt;

    logic [8:0]         r_mem [0:DEPTH-1];
    logic [8:0]         r_ram_q;
    logic [7:0]         r_skid;

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_wr_commit;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_frames_pend;
    logic [IFG_W-1:0]   r_ifg_cnt;

    logic [PW-1:0]      w_used;
    logic [PW-1:0]      w_free;
    logic               w_full;

    logic               w_skid_ld;
    logic               w_wr_en;
    logic               w_wr_last;
    logic               w_ovf;
    logic               w_commit;

    logic               w_rd_en;
    logic               w_drive;
    logic               w_send_last;

    // Occupancy is measured against the read pointer, which only advances as bytes leave.
    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_free      = DEPTH_P - w_used;
    assign w_full      = (w_used == DEPTH_P);
    assign almost_full = (w_free < AF_THR);
    assign tx_busy     = (r_rstate != R_IDLE);

    // Write FSM next-state: the skid byte is flushed on every cycle of W_FRAME, tagged last on valid falling.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_skid_ld    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_last    = 1'b0;
        w_ovf        = 1'b0;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (mac_data_valid) begin
                    w_skid_ld    = 1'b1;
                    w_wstate_nxt = W_FRAME;
                end
            end
            W_FRAME: begin
                w_wr_last = ~mac_data_valid;
                if (w_full) begin
                    w_ovf        = 1'b1;
                    w_wstate_nxt = mac_data_valid ? W_DROP : W_IDLE;
                end else begin
                    w_wr_en = 1'b1;
                    if (mac_data_valid) begin
                        w_skid_ld = 1'b1;
                    end else begin
                        w_commit     = 1'b1;
                        w_wstate_nxt = W_IDLE;
                    end
                end
            end
            W_DROP: begin
                if (!mac_data_valid) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read FSM next-state: each sent byte prefetches the next unless it carries the last flag.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rd_en      = 1'b0;
        w_drive      = 1'b0;
        w_send_last  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (r_frames_pend != '0) begin
                    w_rd_en      = 1'b1;
                    w_rstate_nxt = R_SEND;
                end
            end
            R_SEND: begin
                w_drive = 1'b1;
                if (r_ram_q[8]) begin
                    w_send_last  = 1'b1;
                    w_rstate_nxt = (IFG_BYTES > 1) ? R_IFG : R_IDLE;
                end else begin
                    w_rd_en = 1'b1;
                end
            end
            R_IFG: begin
                if (r_ifg_cnt == '0) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Frame RAM and input skid byte: plain data storage, no reset needed.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {w_wr_last, r_skid};
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        end
        if (w_skid_ld) begin
            r_skid <= mac_tx_data;
        end
    end

    // Write-side state: pointers, commit/rewind, drop pulse and drop statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate       <= W_IDLE;
            r_wr_ptr       <= '0;
            r_wr_commit    <= '0;
            frame_drop     <= 1'b0;
            drop_frame_cnt <= '0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            frame_drop <= w_ovf;
            if (w_ovf) begin
                r_wr_ptr       <= r_wr_commit;
                drop_frame_cnt <= drop_frame_cnt + 16'd1;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_commit) begin
                r_wr_commit <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Committed-frame count shared by both sides; commit and send completion cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frames_pend <= '0;
        end else if (w_commit && !w_send_last) begin
            r_frames_pend <= r_frames_pend + 1'b1;
        end else if (!w_commit && w_send_last) begin
            r_frames_pend <= r_frames_pend - 1'b1;
        end
    end

    // Read-side state: read pointer, registered GMII outputs, IFG timer and TX statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate     <= R_IDLE;
            r_rd_ptr     <= '0;
            r_ifg_cnt    <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_txd     <= 8'h00;
            tx_frame_cnt <= '0;
        end else begin
            r_rstate   <= w_rstate_nxt;
            gmii_tx_en <= w_drive;
            gmii_txd   <= w_drive ? r_ram_q[7:0] : 8'h00;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_send_last) begin
                tx_frame_cnt <= tx_frame_cnt + 16'd1;
                r_ifg_cnt    <= IFG_W'(IFG_LOAD);
            end else if (r_rstate == R_IFG && r_ifg_cnt != '0) begin
                r_ifg_cnt <= r_ifg_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_frame_buf.sv
// Testbench for gmii_tx_frame_buf: directed frames, byte scoreboard fed by the driver,
// independent GMII monitor that pops and compares every transmitted byte and burst.
module tb_gmii_tx_frame_buf;

    localparam int ADDR_W     = 11;
    localparam int IFG_BYTES  = 12;
    // Raised from 1600 so that 64-byte traffic can actually cross the threshold
    // (input outpaces GMII by only 11 bytes per frame).
    localparam int AFULL_FREE = 1900;
    localparam int DEPTH      = 2**ADDR_W;
    localparam int AF_OCC     = DEPTH - AFULL_FREE;   // almost_full once occupancy exceeds this

    logic        clk = 1'b0;
    logic        rst;
    logic        mac_data_valid;
    logic [7:0]  mac_tx_data;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        almost_full;
    logic        frame_drop;
    logic        tx_busy;
    logic [15:0] tx_frame_cnt;
    logic [15:0] drop_frame_cnt;

    gmii_tx_frame_buf #(
        .ADDR_W    (ADDR_W),
        .IFG_BYTES (IFG_BYTES),
        .AFULL_FREE(AFULL_FREE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mac_data_valid(mac_data_valid),
        .mac_tx_data   (mac_tx_data),
        .gmii_tx_en    (gmii_tx_en),
        .gmii_txd      (gmii_txd),
        .almost_full   (almost_full),
        .frame_drop    (frame_drop),
        .tx_busy       (tx_busy),
        .tx_frame_cnt  (tx_frame_cnt),
        .drop_frame_cnt(drop_frame_cnt)
    );

    always #4 clk = ~clk;

    logic [7:0] exp_q[$];
    int         len_q[$];
    int         tests = 0;
    int         fails = 0;

    int         burst_len = 0;
    int         gap_len   = 0;
    int         last_gap  = 0;
    bit         prev_en   = 1'b0;
    int         drop_pulses = 0;
    longint     bytes_in  = 0;
    longint     bytes_out = 0;
    bit         af_chk    = 1'b0;
    bit         af_seen   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s at %0t", name, msg, $time);
    endtask

    // Monitor: compares GMII against the scoreboard, measures bursts and gaps.
    always @(negedge clk) begin
        if (rst) begin
            burst_len = 0;
            gap_len   = 0;
            prev_en   = 1'b0;
        end else begin
            if (frame_drop) drop_pulses++;
            if (gmii_tx_en) begin
                if (!prev_en) last_gap = gap_len;
                if (exp_q.size() == 0) begin
                    fail_now("tx_byte", $sformatf("got 0x%02h with no byte expected", gmii_txd));
                end else begin
                    check("tx_byte", gmii_txd, exp_q.pop_front());
                end
                burst_len++;
                bytes_out++;
            end else begin
                check("txd_idle_zero", gmii_txd, 0);
                if (prev_en) begin
                    if (len_q.size() == 0) begin
                        fail_now("burst_len", $sformatf("burst of %0d with no frame expected", burst_len));
                    end else begin
                        check("burst_len", burst_len, len_q.pop_front());
                    end
                    burst_len = 0;
                    gap_len   = 0;
                end
                gap_len++;
            end
            prev_en = gmii_tx_en;
            if (af_chk) begin
                if (almost_full) af_seen = 1'b1;
                if (bytes_in - bytes_out > AF_OCC + 4) check("almost_full_hi", almost_full, 1);
                if (bytes_in - bytes_out < AF_OCC - 4) check("almost_full_lo", almost_full, 0);
            end
        end
    end

    task automatic send_frame(input int len, input int seed, input bit expect_tx);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            mac_data_valid = 1'b1;
            mac_tx_data    = 8'(seed + i);
            if (expect_tx) exp_q.push_back(8'(seed + i));
            bytes_in++;
        end
        if (expect_tx) len_q.push_back(len);
        @(posedge clk); #1;
        mac_data_valid = 1'b0;
        mac_tx_data    = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && len_q.size() == 0 && !tx_busy && !gmii_tx_en) done = 1'b1;
        end
        if (!done) fail_now(name, "timeout waiting for transmit to drain");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_en"},    gmii_tx_en,     0);
        check({tag, "_txd"},      gmii_txd,       0);
        check({tag, "_afull"},    almost_full,    0);
        check({tag, "_drop"},     frame_drop,     0);
        check({tag, "_busy"},     tx_busy,        0);
        check({tag, "_txcnt"},    tx_frame_cnt,   0);
        check({tag, "_dropcnt"},  drop_frame_cnt, 0);
    endtask

    initial begin
        int lat;
        int d0;
        bit seen;
        rst            = 1'b1;
        mac_data_valid = 1'b0;
        mac_tx_data    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // 1) 64-byte frame 00..3F, latency from valid falling to tx_en rising
        send_frame(64, 8'h00, 1'b1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (gmii_tx_en) begin
                lat = i;
                break;
            end
        end
        check("t1_latency", lat, 3);
        wait_idle("t1_drain");
        check("t1_tx_frame_cnt", tx_frame_cnt, 1);

        // 2) two 60-byte frames, one idle input cycle apart
        send_frame(60, 8'h40, 1'b1);
        send_frame(60, 8'h80, 1'b1);
        wait_idle("t2_drain");
        check("t2_ifg", last_gap, IFG_BYTES);
        check("t2_tx_frame_cnt", tx_frame_cnt, 3);

        // 3) oversize frame dropped, following frame intact
        d0 = drop_pulses;
        send_frame(2100, 8'h00, 1'b0);
        send_frame(64, 8'hC0, 1'b1);
        wait_idle("t3_drain");
        check("t3_drop_pulses", drop_pulses - d0, 1);
        check("t3_drop_frame_cnt", drop_frame_cnt, 1);
        check("t3_tx_frame_cnt", tx_frame_cnt, 4);

        // 4) 30 x 64-byte frames back-to-back, almost_full tracked against occupancy
        bytes_in  = 0;
        bytes_out = 0;
        af_seen   = 1'b0;
        af_chk    = 1'b1;
        for (int f = 0; f < 30; f++) send_frame(64, f * 7, 1'b1);
        wait_idle("t4_drain");
        af_chk = 1'b0;
        check("t4_afull_seen", af_seen, 1);
        check("t4_afull_end", almost_full, 0);
        check("t4_tx_frame_cnt", tx_frame_cnt, 34);

        // 5) 1-byte frames A5 then 5A: single-cycle bursts with full IFG between
        send_frame(1, 8'hA5, 1'b1);
        send_frame(1, 8'h5A, 1'b1);
        wait_idle("t5_drain");
        check("t5_ifg", last_gap, IFG_BYTES);
        check("t5_tx_frame_cnt", tx_frame_cnt, 36);

        // 6) reset in the middle of a burst, then a clean frame
        send_frame(64, 8'h11, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (burst_len >= 20) seen = 1'b1;
        end
        if (!seen) fail_now("t6_mid_burst", "burst never reached byte 20");
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        len_q.delete();
        #1;
        check("t6_async_tx_en", gmii_tx_en, 0);
        check("t6_async_txcnt", tx_frame_cnt, 0);
        @(posedge clk); #1;
        check_all_zero("t6_reset");
        rst = 1'b0;
        send_frame(64, 8'h33, 1'b1);
        wait_idle("t6_drain");
        check("t6_tx_frame_cnt", tx_frame_cnt, 1);
        check("t6_drop_frame_cnt", drop_frame_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
